mul_seq_ctrl: RTL and testbench

Iterative multiply sequencer for the EX stage of the pipelined RISC-V core. When the instruction in EX is a MUL, this block accepts its two register operands and runs a fixed-latency shift-add multiply over XLEN cycles. It holds `stall_o` high to freeze IF/ID/EX until the product is ready, then presents the low XLEN bits of the product on `result_o` for the EX/MEM latch. Non-MUL instructions pass through the normal ALU path and are ignored here.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/mul_shift_add_dp.sv | 43 ++++
 rtl/mul_seq_ctrl.sv | 94 +++++++++
 tb/tb_mul_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: multiply sequencer state encoding, MUL decode
// constants and default datapath width.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned CNT_W_DEFAULT = 6;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
  localparam logic [2:0] MUL_FUNCT3 = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // ID-stage helper producing the is_mul flag that feeds the sequencer.
  function automatic logic is_mul_insn(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[14:12] == MUL_FUNCT3) &&
           (insn[31:25] == MUL_FUNCT7);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand/multiplier shift registers and
// the accumulator, sequenced by load/step/clr from mul_seq_ctrl.
module mul_shift_add_dp
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            clr,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] acc_next
);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplr;
  logic [XLEN-1:0] acc;

  // Accumulator value after the current step; also tapped as the final product.
  always_comb begin
    acc_next = acc;
    if (mplr[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= rs1_data;
      mplr  <= rs2_data;
      acc   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Fixed-latency iterative MUL sequencer for EX: stalls the front end for
// XLEN+1 cycles, then pulses done_o with the low XLEN product bits.
module mul_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            valid_i,
  input  logic            is_mul_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  mul_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic            req;
  logic            last_iter;
  logic            dp_clr;
  logic            dp_load;
  logic            dp_step;
  logic [XLEN-1:0] acc_next;

  always_comb begin
    req       = start_i & valid_i & is_mul_i & ~flush_i;
    last_iter = (cnt == CNT_W'(XLEN - 1));
    dp_clr    = rst_i | ((state == ST_BUSY) & flush_i);
    dp_load   = (state == ST_IDLE) & req;
    dp_step   = (state == ST_BUSY) & ~flush_i;
    // Combinational from IDLE so the MUL is frozen in EX on its first cycle.
    stall_o   = ~rst_i & (((state == ST_IDLE) & req) | (state == ST_BUSY));
  end

  mul_shift_add_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk_i    (clk_i),
    .clr      (dp_clr),
    .load     (dp_load),
    .step     (dp_step),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (req) begin
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              result_o <= acc_next;
              done_o   <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // The request still visible here is the instruction just completed.
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl with hand-computed products
// and cycle positions.
module tb_mul_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        valid_i;
  logic        is_mul_i;
  logic        flush_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;

  mul_seq_ctrl #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .valid_i    (valid_i),
    .is_mul_i   (is_mul_i),
    .flush_i    (flush_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one MUL in the current cycle (cycle 0) and waits for done_o.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit keep,
                         output int scnt, output int dcyc, output logic [31:0] res,
                         output logic done_stall);
    rs1_data_i = a;
    rs2_data_i = b;
    valid_i    = 1'b1;
    is_mul_i   = 1'b1;
    scnt       = 0;
    dcyc       = -1;
    res        = 'x;
    done_stall = 1'bx;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (done_o) begin
        dcyc       = i;
        res        = result_o;
        done_stall = stall_o;
        break;
      end
      if (stall_o) scnt++;
      tick();
    end
    if (!keep) begin
      valid_i  = 1'b0;
      is_mul_i = 1'b0;
    end
  endtask

  task automatic count_idle(input int n, output int stalls, output int dones);
    stalls = 0;
    dones  = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (stall_o) stalls++;
      if (done_o) dones++;
      tick();
    end
  endtask

  int          scnt, dcyc, scnt2, dcyc2, ns, nd;
  logic [31:0] res, res2;
  logic        dstall, dstall2;

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b1;
    valid_i    = 1'b1;
    is_mul_i   = 1'b1;
    flush_i    = 1'b0;
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd5;
    tick();
    tick();
    tick();
    #1;
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_done", {31'b0, done_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    rst_i    = 1'b0;
    valid_i  = 1'b0;
    is_mul_i = 1'b0;
    tick();

    // Basic 3 x 5
    run_mul(32'd3, 32'd5, 1'b0, scnt, dcyc, res, dstall);
    check("basic_stall_cycles", scnt, 33);
    check("basic_done_cycle", dcyc, 33);
    check("basic_result", res, 32'd15);
    check("basic_done_stall", {31'b0, dstall}, 32'd0);
    tick();
    #1;
    check("basic_done_pulse_end", {31'b0, done_o}, 32'd0);
    check("basic_idle_stall", {31'b0, stall_o}, 32'd0);
    check("basic_result_hold", result_o, 32'd15);
    tick();

    // Wrap-around and signed operands
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, scnt, dcyc, res, dstall);
    check("wrap1_result", res, 32'hFFFF_FFFE);
    check("wrap1_done_cycle", dcyc, 33);
    tick();
    run_mul(32'h8000_0000, 32'h8000_0000, 1'b0, scnt, dcyc, res, dstall);
    check("wrap2_result", res, 32'h0000_0000);
    tick();
    run_mul(32'hFFFF_FFFD, 32'd5, 1'b0, scnt, dcyc, res, dstall);
    check("signed_result", res, 32'hFFFF_FFF1);
    tick();

    // Back-to-back: first MUL stays visible through its DONE cycle
    run_mul(32'd7, 32'd6, 1'b1, scnt, dcyc, res, dstall);
    check("b2b1_done_cycle", dcyc, 33);
    check("b2b1_result", res, 32'd42);
    check("b2b1_done_stall", {31'b0, dstall}, 32'd0);
    tick();
    run_mul(32'h0001_0000, 32'h0001_0000, 1'b0, scnt2, dcyc2, res2, dstall2);
    check("b2b2_done_cycle", 34 + dcyc2, 67);
    check("b2b2_stall_cycles", scnt2, 33);
    check("b2b2_result", res2, 32'd0);
    tick();

    // Flush at BUSY cycle 10
    run_mul(32'd11, 32'd13, 1'b0, scnt, dcyc, res, dstall);
    check("preflush_result", res, 32'd143);
    tick();
    rs1_data_i = 32'd9;
    rs2_data_i = 32'd9;
    valid_i    = 1'b1;
    is_mul_i   = 1'b1;
    #1;
    check("flush_c0_stall", {31'b0, stall_o}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    flush_i = 1'b1;
    #1;
    check("flush_c10_stall", {31'b0, stall_o}, 32'd1);
    tick();
    flush_i  = 1'b0;
    valid_i  = 1'b0;
    is_mul_i = 1'b0;
    #1;
    check("flush_next_stall", {31'b0, stall_o}, 32'd0);
    count_idle(40, ns, nd);
    check("flush_no_done", nd, 0);
    check("flush_result_hold", result_o, 32'd143);

    // Flush together with a request in IDLE
    valid_i  = 1'b1;
    is_mul_i = 1'b1;
    flush_i  = 1'b1;
    #1;
    check("idle_flush_stall", {31'b0, stall_o}, 32'd0);
    tick();
    flush_i  = 1'b0;
    valid_i  = 1'b0;
    is_mul_i = 1'b0;
    count_idle(40, ns, nd);
    check("idle_flush_stalls", ns, 0);
    check("idle_flush_dones", nd, 0);

    // Reset at BUSY cycle 20
    rs1_data_i = 32'h1234;
    rs2_data_i = 32'h10;
    valid_i    = 1'b1;
    is_mul_i   = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rst_i = 1'b1;
    #1;
    check("rst_mid_stall_now", {31'b0, stall_o}, 32'd0);
    tick();
    rst_i    = 1'b0;
    valid_i  = 1'b0;
    is_mul_i = 1'b0;
    #1;
    check("rst_mid_done", {31'b0, done_o}, 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    count_idle(40, ns, nd);
    check("rst_mid_no_done", nd, 0);

    // start_i low blocks acceptance; non-MUL is ignored
    start_i    = 1'b0;
    valid_i    = 1'b1;
    is_mul_i   = 1'b1;
    rs1_data_i = 32'd5;
    rs2_data_i = 32'd5;
    count_idle(40, ns, nd);
    check("nostart_stalls", ns, 0);
    check("nostart_dones", nd, 0);
    start_i  = 1'b1;
    is_mul_i = 1'b0;
    count_idle(10, ns, nd);
    check("nonmul_stalls", ns, 0);
    valid_i = 1'b0;
    tick();

    // start_i dropped mid-BUSY still completes on schedule
    rs1_data_i = 32'd123;
    rs2_data_i = 32'd456;
    valid_i    = 1'b1;
    is_mul_i   = 1'b1;
    scnt = 0;
    dcyc = -1;
    res  = 'x;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) start_i = 1'b0;
      #1;
      if (done_o) begin
        dcyc = i;
        res  = result_o;
        break;
      end
      if (stall_o) scnt++;
      tick();
    end
    valid_i  = 1'b0;
    is_mul_i = 1'b0;
    check("startdrop_done_cycle", dcyc, 33);
    check("startdrop_stall_cycles", scnt, 33);
    check("startdrop_result", res, 32'd56088);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
